// File: rtl/pamux_bram_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : pamux_if
// Purpose  : Parallel address-multiplexed bus between a requester and a
//            memory-style responder.
// Signals  : address[21:0]   request address (bits 21:14 select a 16 KB window)
//            write, read     request strobes, active high
//            write_data[7:0] data for write requests
//            read_data[7:0]  data returned by the last completed read
//            busy            responder is working on a request
// Revision : 1.0 - initial release
// ============================================================================
interface pamux_if;
  logic [21:0] address;
  logic        write;
  logic        read;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        busy;

  modport server (
    input  address,
    input  write,
    input  read,
    input  write_data,
    output read_data,
    output busy
  );

  modport client (
    output address,
    output write,
    output read,
    output write_data,
    input  read_data,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/pamux_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : pamux_bram_responder
// Purpose  : Serves a 16 KB window of the pamux address space from an inferred
//            16384 x 8 block RAM. Each access runs IDLE -> ACCESS -> WAIT ->
//            DONE with busy held high for 3 + WAIT_CYCLES cycles.
// Params   : TOP_ADDR_BITS  address[21:14] value that selects this window
//            WAIT_CYCLES    extra busy cycles per access (0..15)
// Ports    : i_CLK          clock
//            i_RST_n        synchronous active-low reset
//            bus_Pamux      pamux_if server side
//            o_OVERRUN      sticky: a new strobe arrived while busy
// Revision : 1.0 - initial release
// ============================================================================
module pamux_bram_responder #(
  parameter logic [7:0] TOP_ADDR_BITS = 8'b0000_0001,
  parameter int         WAIT_CYCLES   = 2
) (
  input  logic    i_CLK,
  input  logic    i_RST_n,
  pamux_if.server bus_Pamux,
  output logic    o_OVERRUN
);

  localparam logic [3:0] c_WAIT      = 4'(WAIT_CYCLES);
  localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_done_ph, w_done_ph_nxt;
  logic        w_accept;
  logic        w_ram_we, w_ram_re;

  logic [13:0] r_idx;
  logic        r_in_win;
  logic        r_is_wr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_ram_q;
  logic [7:0]  r_rdata;
  logic        r_overrun;
  logic        r_strobe_q;

  logic [7:0]  r_mem [0:16383];

  // An undriven (z/x) strobe must not look like a request, hence ===.
  logic w_wr, w_rd, w_strobe;
  assign w_wr     = (bus_Pamux.write === 1'b1);
  assign w_rd     = (bus_Pamux.read === 1'b1);
  assign w_strobe = w_wr | w_rd;

  // --------------------------------------------------------------------------
  // Next-state logic. DONE spans two cycles: the first lets the BRAM output
  // register settle onto the response path, the second forwards it to
  // read_data and drops busy.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_done_ph_nxt = r_done_ph;
    w_accept      = 1'b0;
    w_ram_we      = 1'b0;
    w_ram_re      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Reset on this edge aborts the access before it touches the RAM.
        w_ram_we      = r_is_wr & r_in_win & i_RST_n;
        w_ram_re      = ~r_is_wr & r_in_win;
        w_cnt_nxt     = 4'd0;
        w_done_ph_nxt = 1'b0;
        w_state_nxt   = (c_WAIT != 4'd0) ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (r_cnt == c_WAIT_LAST) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        if (r_done_ph) begin
          w_done_ph_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_done_ph_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and response registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_done_ph  <= 1'b0;
      r_idx      <= 14'd0;
      r_in_win   <= 1'b0;
      r_is_wr    <= 1'b0;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_overrun  <= 1'b0;
      r_strobe_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done_ph  <= w_done_ph_nxt;
      r_strobe_q <= w_strobe;

      // Write has priority when both strobes arrive together.
      if (w_accept) begin
        r_idx    <= bus_Pamux.address[13:0];
        r_in_win <= (bus_Pamux.address[21:14] == TOP_ADDR_BITS);
        r_is_wr  <= w_wr;
        r_wdata  <= bus_Pamux.write_data;
      end

      // Only a fresh assertion counts as a stray request; a strobe simply
      // held from the accepted request is the same request.
      if ((r_state != S_IDLE) && w_strobe && !r_strobe_q) begin
        r_overrun <= 1'b1;
      end

      if ((r_state == S_DONE) && r_done_ph && !r_is_wr) begin
        r_rdata <= r_in_win ? r_ram_q : 8'hFF;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Block RAM: no reset, no initial contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (w_ram_we) begin
      r_mem[r_idx] <= r_wdata;
    end
    if (w_ram_re) begin
      r_ram_q <= r_mem[r_idx];
    end
  end

  assign bus_Pamux.busy      = (r_state != S_IDLE);
  assign bus_Pamux.read_data = r_rdata;
  assign o_OVERRUN           = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pamux_bram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pamux_bram_responder
// Purpose  : Self-checking bench for pamux_bram_responder. Two instances:
//            u_dut0 with WAIT_CYCLES=2 and u_dut1 with WAIT_CYCLES=0, both
//            serving window 8'h01. Expected responses are queued when a
//            request is driven and compared when busy falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pamux_bram_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pamux_if u_bus0 ();
  pamux_if u_bus1 ();
  logic    ovr0, ovr1;

  logic [21:0] t_addr [2];
  logic        t_wr   [2];
  logic        t_rd   [2];
  logic [7:0]  t_wd   [2];

  assign u_bus0.address    = t_addr[0];
  assign u_bus0.write      = t_wr[0];
  assign u_bus0.read       = t_rd[0];
  assign u_bus0.write_data = t_wd[0];
  assign u_bus1.address    = t_addr[1];
  assign u_bus1.write      = t_wr[1];
  assign u_bus1.read       = t_rd[1];
  assign u_bus1.write_data = t_wd[1];

  logic       w_busy  [2];
  logic [7:0] w_rdata [2];
  logic       w_ovr   [2];
  assign w_busy[0]  = u_bus0.busy;
  assign w_busy[1]  = u_bus1.busy;
  assign w_rdata[0] = u_bus0.read_data;
  assign w_rdata[1] = u_bus1.read_data;
  assign w_ovr[0]   = ovr0;
  assign w_ovr[1]   = ovr1;

  pamux_bram_responder #(.TOP_ADDR_BITS(8'h01), .WAIT_CYCLES(2)) u_dut0 (
    .i_CLK     (clk),
    .i_RST_n   (rst_n),
    .bus_Pamux (u_bus0.server),
    .o_OVERRUN (ovr0)
  );

  pamux_bram_responder #(.TOP_ADDR_BITS(8'h01), .WAIT_CYCLES(0)) u_dut1 (
    .i_CLK     (clk),
    .i_RST_n   (rst_n),
    .bus_Pamux (u_bus1.server),
    .o_OVERRUN (ovr1)
  );

  // Reference model and scoreboard
  typedef struct {
    logic [7:0] rd;
    int         len;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] m_mem [int];
  logic [7:0] m_last [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request on instance sel; strobe is high for one cycle (or re-pulsed
  // two cycles after the first sample when retrig is set).
  task automatic access(input int sel, input bit is_wr, input bit both,
                        input logic [7:0] top, input logic [13:0] idx,
                        input logic [7:0] wd, input bit retrig, input string tag);
    exp_t       e;
    int         len;
    int         key;
    bit         inwin;
    logic [7:0] exp_rd;
    inwin = (top == 8'h01);
    key   = sel * 65536 + int'(idx);
    if (is_wr) begin
      if (inwin) m_mem[key] = wd;
      exp_rd = m_last[sel];
    end else begin
      exp_rd = inwin ? m_mem[key] : 8'hFF;
      m_last[sel] = exp_rd;
    end
    e.rd  = exp_rd;
    e.len = (sel == 0) ? 5 : 3;
    sb_q.push_back(e);

    @(negedge clk);
    t_addr[sel] = {top, idx};
    t_wd[sel]   = wd;
    t_wr[sel]   = is_wr;
    t_rd[sel]   = !is_wr || both;
    @(negedge clk);
    t_wr[sel] = 1'b0;
    t_rd[sel] = 1'b0;
    len = 0;
    while (w_busy[sel] && len < 64) begin
      len++;
      if (retrig && len == 2) t_rd[sel] = 1'b1;
      if (retrig && len == 3) t_rd[sel] = 1'b0;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check({tag, "_busy_len"}, len, e.len);
    check({tag, "_rdata"}, w_rdata[sel], e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   rise [$];
    int   cyc;
    int   gap;
    int   guard;
    logic prevb;

    for (int i = 0; i < 2; i++) begin
      t_addr[i] = '0; t_wr[i] = 1'b0; t_rd[i] = 1'b0; t_wd[i] = '0;
      m_last[i] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_busy", w_busy[0], 1'b0);
    check("rst_rdata", w_rdata[0], 8'h00);
    check("rst_ovr", w_ovr[0], 1'b0);
    check("rst_busy1", w_busy[1], 1'b0);

    // Basic write/read
    access(0, 1, 0, 8'h01, 14'h0123, 8'h5A, 0, "wr_0123");
    access(0, 0, 0, 8'h01, 14'h0123, 8'h00, 0, "rd_0123");

    // Out-of-window write is dropped, read returns FF
    access(0, 1, 0, 8'h00, 14'h0123, 8'h33, 0, "wr_oow");
    access(0, 0, 0, 8'h00, 14'h0123, 8'h00, 0, "rd_oow");
    access(0, 0, 0, 8'h01, 14'h0123, 8'h00, 0, "rd_after_oow");

    // Simultaneous write and read: write wins, no overrun
    access(0, 1, 1, 8'h01, 14'h0200, 8'hA5, 0, "wr_both");
    check("both_ovr", w_ovr[0], 1'b0);
    access(0, 0, 0, 8'h01, 14'h0200, 8'h00, 0, "rd_both");

    // Strobe re-asserted while busy
    access(0, 0, 0, 8'h01, 14'h0123, 8'h00, 1, "rd_retrig");
    check("retrig_ovr", w_ovr[0], 1'b1);

    // Reset during WAIT of a read, with a strobe presented during reset
    @(negedge clk);
    t_addr[0] = {8'h01, 14'h0123};
    t_rd[0]   = 1'b1;
    @(negedge clk);
    t_rd[0] = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    t_rd[0] = 1'b1;
    @(negedge clk);
    check("rstmid_busy", w_busy[0], 1'b0);
    check("rstmid_rdata", w_rdata[0], 8'h00);
    check("rstmid_ovr", w_ovr[0], 1'b0);
    rst_n   = 1'b1;
    t_rd[0] = 1'b0;
    m_last[0] = 8'h00;
    m_last[1] = 8'h00;
    @(negedge clk);
    check("rst_strobe_ignored", w_busy[0], 1'b0);
    access(0, 0, 0, 8'h01, 14'h0123, 8'h00, 0, "rd_after_rst");

    // WAIT_CYCLES=0 instance: window boundaries
    access(1, 1, 0, 8'h01, 14'h0000, 8'h11, 0, "w0_wr_lo");
    access(1, 1, 0, 8'h01, 14'h3FFF, 8'hEE, 0, "w0_wr_hi");
    access(1, 0, 0, 8'h01, 14'h0000, 8'h00, 0, "w0_rd_lo");
    access(1, 0, 0, 8'h01, 14'h3FFF, 8'h00, 0, "w0_rd_hi");
    access(1, 0, 0, 8'h02, 14'h0000, 8'h00, 0, "w0_rd_nowrap");

    // Held strobe: back-to-back requests every 3+0+1 cycles, no overrun
    @(negedge clk);
    t_addr[1] = {8'h01, 14'h0000};
    t_rd[1]   = 1'b1;
    prevb = 1'b0;
    cyc   = 0;
    repeat (12) begin
      @(negedge clk);
      cyc++;
      if (w_busy[1] && !prevb) rise.push_back(cyc);
      prevb = w_busy[1];
    end
    t_rd[1] = 1'b0;
    gap = (rise.size() >= 2) ? (rise[1] - rise[0]) : -1;
    check("held_period", gap, 4);
    check("held_ovr", w_ovr[1], 1'b0);
    guard = 0;
    while (w_busy[1] && guard < 64) begin
      guard++;
      @(negedge clk);
    end
    check("held_drain", w_busy[1], 1'b0);
    check("held_rdata", w_rdata[1], 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pamux_bram_responder.md
PAMUX_BRAM_RESPONDER -- requirements
Module: pamux_bram_responder

Interface
REQ-001 SHALL have parameter TOP_ADDR_BITS, default 8'b0000_0001: required value of address[21:14], the 16 KB window served.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra busy cycles per access, legal range 0..15.
REQ-003 SHALL have port i_CLK, input, 1: the single clock.
REQ-004 SHALL have port i_RST_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port bus_Pamux, pamux_if.server: address in 22, write in 1, read in 1, write_data in 8, read_data out 8, busy out 1.
REQ-006 SHALL have port o_OVERRUN, output, 1: sticky flag for a strobe received while busy.

Function
REQ-007 SHALL contain 16384 x 8 inferred block RAM, indexed by address[13:0]; contents are not initialised or reset.
REQ-008 SHALL treat write/read as asserted only when sampled exactly 1; z/x (bus undriven) counts as deasserted.
REQ-009 SHALL implement states IDLE, ACCESS, WAIT, DONE.
REQ-010 IDLE: on an edge sampling write=1 or read=1, SHALL latch address, write_data and operation, set busy=1 on that same edge, go to ACCESS.
REQ-011 Write and read both 1 in the same cycle: write SHALL win, read discarded, o_OVERRUN unchanged.
REQ-012 ACCESS (one cycle): in-window write SHALL commit to RAM; in-window read SHALL issue the RAM read; then WAIT if WAIT_CYCLES>0, else DONE.
REQ-013 WAIT: 4-bit counter SHALL count WAIT_CYCLES cycles, then go to DONE.
REQ-014 DONE: SHALL register read_data (RAM output for a read, unchanged for a write), clear busy on the same edge, return to IDLE.
REQ-015 busy SHALL therefore be high for exactly 3+WAIT_CYCLES cycles per access, going high the cycle after the strobe is first seen.
REQ-016 read_data SHALL stay stable from busy falling until the next read completes; writes SHALL not alter it.
REQ-017 Out-of-window access (address[21:14] != TOP_ADDR_BITS): SHALL run identical state sequence and busy timing; write discarded; read returns 8'hFF.
REQ-018 Strobe seen in ACCESS, WAIT or DONE SHALL be ignored and SHALL set o_OVERRUN=1 until reset.
REQ-019 Strobe held high across several cycles SHALL be one request; after busy falls, a strobe still high SHALL start a new request.
REQ-020 Next request SHALL be accepted in the first IDLE cycle after DONE, giving back-to-back period 3+WAIT_CYCLES+1 cycles.
REQ-021 Addresses 0x0000 and 0x3FFF within the window SHALL be accessible; no wrap into adjacent windows.

Reset
REQ-022 With i_RST_n=0 at an edge: state IDLE, busy=0, read_data=8'h00, o_OVERRUN=0, counter=0.
REQ-023 Reset mid-operation SHALL abort the access; a write already committed in ACCESS stays in RAM; a pending read is lost; busy=0 after that edge.
REQ-024 Strobes sampled while i_RST_n=0 SHALL be ignored.

Verification
REQ-025 Write 0x5A at {TOP_ADDR_BITS,14'h0123}, WAIT_CYCLES=2, then read same address -> busy high 5 cycles each, read_data=8'h5A when busy falls.
REQ-026 Read at address[21:14]=8'h00 (out of window) -> busy high 5 cycles, read_data=8'hFF; prior write there leaves RAM unchanged.
REQ-027 write=1 and read=1 in same cycle with write_data=8'hA5 -> RAM holds 8'hA5, read_data unchanged, o_OVERRUN=0.
REQ-028 Read strobe asserted again 2 cycles after first strobe -> ignored, o_OVERRUN=1, first read completes with normal timing.
REQ-029 Reset asserted during WAIT of a read -> busy=0 and read_data=8'h00 next cycle; subsequent read returns correct data.
REQ-030 WAIT_CYCLES=0, back-to-back writes to 14'h0000 and 14'h3FFF then reads -> busy 3 cycles each, both values returned.
